// File: rtl/sram_arbiter.sv
// Two-port arbiter in front of a single-port SRAM with lock/ownership; SRAM_ARB_RR_EN selects round-robin, else fixed priority to port 0.
// Zero-cycle grant (ready depends only on valids and ownership); read data returns one cycle after acceptance.
// A requester is held off simply by withholding its ready; there is no queueing.
module sram_arbiter #(
  parameter  int WIDTH = 8,
  parameter  int DEPTH = 2048,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             p0_valid,
  input  logic             p1_valid,
  output logic             p0_ready,
  output logic             p1_ready,
  input  logic             p0_wr,
  input  logic             p1_wr,
  input  logic             p0_lock,
  input  logic             p1_lock,
  input  logic [AW-1:0]    p0_addr,
  input  logic [AW-1:0]    p1_addr,
  input  logic [WIDTH-1:0] p0_wdata,
  input  logic [WIDTH-1:0] p1_wdata,
  output logic             p0_rvalid,
  output logic             p1_rvalid,
  output logic [WIDTH-1:0] rdata,
  output logic [AW-1:0]    sram_addr,
  output logic             sram_rd_o_wr,
  output logic [WIDTH-1:0] sram_wdata,
  input  logic [WIDTH-1:0] sram_rdata
);

  logic own_vld;
  logic own_id;
  logic own_active;
  logic g0;
  logic g1;

`ifdef SRAM_ARB_RR_EN
  logic last_gnt;
`endif

  // An owner that drops valid forfeits its claim in the same cycle.
  assign own_active = own_vld & (own_id ? p1_valid : p0_valid);

  always_comb begin
    g0 = 1'b0;
    g1 = 1'b0;
    if (!rst) begin
      if (own_active) begin
        g0 = ~own_id;
        g1 = own_id;
      end else if (p0_valid && p1_valid) begin
`ifdef SRAM_ARB_RR_EN
        g0 = last_gnt;
        g1 = ~last_gnt;
`else
        g0 = 1'b1;
`endif
      end else begin
        g0 = p0_valid;
        g1 = p1_valid;
      end
    end
  end

  assign p0_ready = g0;
  assign p1_ready = g1;
  assign rdata    = sram_rdata;

  always_comb begin
    sram_addr    = '0;
    sram_rd_o_wr = 1'b0;
    sram_wdata   = '0;
    if (g0) begin
      sram_addr    = p0_addr;
      sram_rd_o_wr = p0_wr;
      sram_wdata   = p0_wdata;
    end else if (g1) begin
      sram_addr    = p1_addr;
      sram_rd_o_wr = p1_wr;
      sram_wdata   = p1_wdata;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      own_vld   <= 1'b0;
      own_id    <= 1'b0;
      p0_rvalid <= 1'b0;
      p1_rvalid <= 1'b0;
    end else begin
      p0_rvalid <= g0 & ~p0_wr;
      p1_rvalid <= g1 & ~p1_wr;
      if (g0 || g1) begin
        own_vld <= g0 ? p0_lock : p1_lock;
        own_id  <= g1;
      end else if (own_vld) begin
        // No grant while owned means the owner went idle.
        own_vld <= 1'b0;
      end
    end
  end

`ifdef SRAM_ARB_RR_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_gnt <= 1'b1;
    end else if (g0 || g1) begin
      last_gnt <= g1;
    end
  end
`endif

endmodule

// File: tb/tb_sram_arbiter.sv
// Scoreboard bench for sram_arbiter: behavioural SRAM, per-cycle grant/SRAM-bus checks, queued read-data expectations.
module tb_sram_arbiter;
  localparam int WIDTH = 8;
  localparam int DEPTH = 2048;
  localparam int AW    = 11;
`ifdef SRAM_ARB_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic             p0_valid, p1_valid, p0_ready, p1_ready;
  logic             p0_wr, p1_wr, p0_lock, p1_lock;
  logic [AW-1:0]    p0_addr, p1_addr;
  logic [WIDTH-1:0] p0_wdata, p1_wdata;
  logic             p0_rvalid, p1_rvalid;
  logic [WIDTH-1:0] rdata;
  logic [AW-1:0]    sram_addr;
  logic             sram_rd_o_wr;
  logic [WIDTH-1:0] sram_wdata, sram_rdata;

  sram_arbiter #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .p0_valid(p0_valid), .p1_valid(p1_valid),
    .p0_ready(p0_ready), .p1_ready(p1_ready),
    .p0_wr(p0_wr), .p1_wr(p1_wr),
    .p0_lock(p0_lock), .p1_lock(p1_lock),
    .p0_addr(p0_addr), .p1_addr(p1_addr),
    .p0_wdata(p0_wdata), .p1_wdata(p1_wdata),
    .p0_rvalid(p0_rvalid), .p1_rvalid(p1_rvalid),
    .rdata(rdata),
    .sram_addr(sram_addr), .sram_rd_o_wr(sram_rd_o_wr),
    .sram_wdata(sram_wdata), .sram_rdata(sram_rdata)
  );

  function automatic logic [7:0] pat(input logic [AW-1:0] a);
    return a[7:0] ^ 8'h3C;
  endfunction

  // Behavioural SRAM: unwritten words read back as pat(addr).
  logic [7:0] mem [DEPTH];
  bit         wr_flag [DEPTH];
  always @(posedge clk) begin
    if (sram_rd_o_wr) begin
      mem[sram_addr]     <= sram_wdata;
      wr_flag[sram_addr] <= 1'b1;
    end
    sram_rdata <= wr_flag[sram_addr] ? mem[sram_addr] : pat(sram_addr);
  end

  typedef struct packed {
    logic        port;
    logic [7:0]  data;
    int unsigned cyc;
  } exp_t;

  exp_t        q[$];
  exp_t        m_e;
  exp_t        drop_e;
  logic [7:0]  ref_mem [DEPTH];
  int          n_chk = 0;
  int          n_err = 0;
  int unsigned cyc_cnt = 0;

  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Read-return monitor: exactly one rvalid in the cycle an entry is due, none otherwise.
  always @(negedge clk) begin
    if (q.size() != 0 && q[0].cyc == cyc_cnt) begin
      m_e = q.pop_front();
      check("rvalid", {30'd0, p1_rvalid, p0_rvalid}, m_e.port ? 32'd2 : 32'd1);
      check("rdata", {24'd0, rdata}, {24'd0, m_e.data});
    end else begin
      check("rv_idle", {30'd0, p1_rvalid, p0_rvalid}, 32'd0);
    end
  end

  // One bus cycle; eg = expected grant (0, 1, or 2 for none). Entered and left at posedge+1.
  task automatic cyc(input logic v0, input logic w0, input logic l0,
                     input logic [AW-1:0] a0, input logic [7:0] d0,
                     input logic v1, input logic w1, input logic l1,
                     input logic [AW-1:0] a1, input logic [7:0] d1,
                     input int eg, input string tag);
    logic [AW-1:0] ea;
    logic          ew;
    logic [7:0]    ed;
    p0_valid = v0; p0_wr = w0; p0_lock = l0; p0_addr = a0; p0_wdata = d0;
    p1_valid = v1; p1_wr = w1; p1_lock = l1; p1_addr = a1; p1_wdata = d1;
    ea = '0; ew = 1'b0; ed = '0;
    if (eg == 0) begin
      ea = a0; ew = w0; ed = d0;
      if (w0) ref_mem[a0] = d0;
      else q.push_back(exp_t'{port: 1'b0, data: ref_mem[a0], cyc: cyc_cnt + 1});
    end else if (eg == 1) begin
      ea = a1; ew = w1; ed = d1;
      if (w1) ref_mem[a1] = d1;
      else q.push_back(exp_t'{port: 1'b1, data: ref_mem[a1], cyc: cyc_cnt + 1});
    end
    @(negedge clk);
    check({tag, ".rdy"}, {30'd0, p1_ready, p0_ready},
          (eg == 0) ? 32'd1 : (eg == 1) ? 32'd2 : 32'd0);
    check({tag, ".addr"}, {21'd0, sram_addr}, {21'd0, ea});
    check({tag, ".wr"}, {31'd0, sram_rd_o_wr}, {31'd0, ew});
    check({tag, ".wdata"}, {24'd0, sram_wdata}, {24'd0, ed});
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input string tag);
    cyc(1'b0, 1'b0, 1'b0, '0, 8'h00, 1'b0, 1'b0, 1'b0, '0, 8'h00, 2, tag);
  endtask

  initial begin
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = pat(AW'(i));
    p0_valid = 1'b1; p0_wr = 1'b1; p0_lock = 1'b1; p0_addr = 11'h155; p0_wdata = 8'hFF;
    p1_valid = 1'b1; p1_wr = 1'b0; p1_lock = 1'b1; p1_addr = 11'h2AA; p1_wdata = 8'hEE;

    // Reset state with both requesters pushing.
    repeat (2) @(posedge clk);
    #1;
    check("rst.rdy", {30'd0, p1_ready, p0_ready}, 32'd0);
    check("rst.rv", {30'd0, p1_rvalid, p0_rvalid}, 32'd0);
    check("rst.sram", {20'd0, sram_rd_o_wr, sram_addr}, 32'd0);
    check("rst.wd", {24'd0, sram_wdata}, 32'd0);
    rst = 1'b0;

    // Contention straight out of reset.
    for (int i = 0; i < 6; i++)
      cyc(1'b1, 1'b0, 1'b0, 11'h040 + AW'(i), 8'h00,
          1'b1, 1'b0, 1'b0, 11'h050 + AW'(i), 8'h00, RR ? (i % 2) : 0, "cont");
    idle("idle");

    // Write then read-after-write on the same address.
    cyc(1'b1, 1'b1, 1'b0, 11'h010, 8'hA5, 1'b0, 1'b0, 1'b0, '0, 8'h00, 0, "w010");
    cyc(1'b1, 1'b0, 1'b0, 11'h010, 8'h00, 1'b0, 1'b0, 1'b0, '0, 8'h00, 0, "r010");
    idle("idle");

    // p1 takes and holds the lock while p0 waits.
    cyc(1'b0, 1'b0, 1'b0, '0, 8'h00, 1'b1, 1'b0, 1'b1, 11'h020, 8'h00, 1, "lk0");
    cyc(1'b1, 1'b0, 1'b0, 11'h060, 8'h00, 1'b1, 1'b0, 1'b1, 11'h021, 8'h00, 1, "lk1");
    cyc(1'b1, 1'b0, 1'b0, 11'h060, 8'h00, 1'b1, 1'b0, 1'b1, 11'h022, 8'h00, 1, "lk2");
    cyc(1'b1, 1'b0, 1'b0, 11'h060, 8'h00, 1'b1, 1'b0, 1'b0, 11'h023, 8'h00, 1, "lk3");
    cyc(1'b1, 1'b0, 1'b0, 11'h060, 8'h00, 1'b1, 1'b0, 1'b0, 11'h024, 8'h00, 0, "lk_rel");
    idle("idle");

    // p0 owner drops valid for one cycle.
    cyc(1'b1, 1'b0, 1'b1, 11'h070, 8'h00, 1'b0, 1'b0, 1'b0, '0, 8'h00, 0, "own0");
    cyc(1'b1, 1'b0, 1'b1, 11'h071, 8'h00, 1'b1, 1'b0, 1'b0, 11'h080, 8'h00, 0, "own1");
    cyc(1'b0, 1'b0, 1'b1, 11'h072, 8'h00, 1'b1, 1'b0, 1'b1, 11'h081, 8'h00, 1, "own_drop");
    cyc(1'b1, 1'b0, 1'b0, 11'h073, 8'h00, 1'b1, 1'b0, 1'b0, 11'h082, 8'h00, 1, "p1_owner");
    idle("idle");

    // Asynchronous reset with a read in flight.
    cyc(1'b1, 1'b0, 1'b0, 11'h100, 8'h00, 1'b0, 1'b0, 1'b0, '0, 8'h00, 0, "rst_rd");
    p0_valid = 1'b1; p0_wr = 1'b0; p1_valid = 1'b1; p1_wr = 1'b0;
    #1 rst = 1'b1;
    #1;
    check("arst.rv", {30'd0, p1_rvalid, p0_rvalid}, 32'd0);
    check("arst.rdy", {30'd0, p1_ready, p0_ready}, 32'd0);
    check("arst.addr", {21'd0, sram_addr}, 32'd0);
    drop_e = q.pop_back();
    @(posedge clk);
    #1 rst = 1'b0;
    cyc(1'b1, 1'b0, 1'b0, 11'h101, 8'h00, 1'b1, 1'b0, 1'b0, 11'h102, 8'h00, 0, "post_rst");
    idle("idle");

    // Back-to-back writes then reads.
    for (int i = 0; i < 4; i++)
      cyc(1'b1, 1'b1, 1'b0, AW'(i), 8'h11 + 8'(i), 1'b0, 1'b0, 1'b0, '0, 8'h00, 0, "b2b_wr");
    for (int i = 0; i < 4; i++)
      cyc(1'b1, 1'b0, 1'b0, AW'(i), 8'h00, 1'b0, 1'b0, 1'b0, '0, 8'h00, 0, "b2b_rd");
    idle("idle");
    idle("idle");

    check("sb_empty", q.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
